// File: rtl/id_scoreboard.sv
// Decode-stage issue scheduler: tracks registers with writes in flight and
// decides each cycle whether the ID instruction issues or IF/ID holds.
module id_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [4:0]             id_rs1_addr_i,
    input  logic [4:0]             id_rs2_addr_i,
    input  logic [4:0]             id_rd_addr_i,
    input  logic                   id_reg_wen_i,
    input  logic                   ex_ready_i,
    input  logic                   flush_i,
    input  logic                   wb_wen_i,
    input  logic [4:0]             wb_rd_addr_i,
    output logic                   issue_o,
    output logic                   stall_o,
    output logic [31:0]            busy_o,
    output logic [3:0]             outstanding_o,
    output logic                   err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0]             MAX_OUT  = 4'(MAX_OUTSTANDING);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]            busy_r;
    logic [3:0]             outstanding_r;
    logic                   err_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic                   wr_s;
    logic                   full_s;
    logic                   hazard_s;
    logic                   set_s;
    logic                   clr_s;
    logic                   bad_wb_s;
    logic [31:0]            busy_nxt_s;
    logic [3:0]             outstanding_nxt_s;

    // Hazard detection against registered state; issue/stall are zero-latency.
    always_comb begin
        wr_s     = id_reg_wen_i & (id_rd_addr_i != 5'd0);
        full_s   = (outstanding_r == MAX_OUT);
        hazard_s = id_valid_i & (busy_r[id_rs1_addr_i] | busy_r[id_rs2_addr_i] |
                                 (wr_s & (busy_r[id_rd_addr_i] | full_s)));
        issue_o  = rst_n & id_valid_i & ~flush_i & ~hazard_s & ex_ready_i;
        stall_o  = ~rst_n | (id_valid_i & ~flush_i & (hazard_s | ~ex_ready_i));
        set_s    = issue_o & wr_s;
        clr_s    = wb_wen_i & (wb_rd_addr_i != 5'd0) & busy_r[wb_rd_addr_i];
        bad_wb_s = wb_wen_i & (wb_rd_addr_i != 5'd0) & ~busy_r[wb_rd_addr_i];
    end

    // Next busy bitmap and pending-write count; a set overrides a clear.
    always_comb begin
        busy_nxt_s = busy_r;
        if (clr_s) begin
            busy_nxt_s[wb_rd_addr_i] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_s) begin
            busy_nxt_s[id_rd_addr_i] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;

        outstanding_nxt_s = outstanding_r;
        case ({set_s, clr_s})
            2'b10: begin
                if (outstanding_r != MAX_OUT) begin
                    outstanding_nxt_s = outstanding_r + 4'd1;
                end else begin
                    outstanding_nxt_s = outstanding_r;
                end
            end
            2'b01: begin
                if (outstanding_r != 4'd0) begin
                    outstanding_nxt_s = outstanding_r - 4'd1;
                end else begin
                    outstanding_nxt_s = outstanding_r;
                end
            end
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Scoreboard state, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r        <= 32'd0;
            outstanding_r <= 4'd0;
            err_r         <= 1'b0;
            stall_cnt_r   <= {STALL_CNT_W{1'b0}};
        end else begin
            busy_r        <= busy_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            err_r         <= err_r | bad_wb_s;
            if (stall_o && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign busy_o        = busy_r;
    assign outstanding_o = outstanding_r;
    assign err_o         = err_r;
    assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed vector bench for id_scoreboard: each row is one cycle of inputs plus
// the expected combinational outputs and the registered state seen before the edge.
module tb_id_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_reg_wen_i;
    logic        ex_ready_i;
    logic        flush_i;
    logic        wb_wen_i;
    logic [4:0]  wb_rd_addr_i;
    logic        issue_o;
    logic        stall_o;
    logic [31:0] busy_o;
    logic [3:0]  outstanding_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    int checks;
    int errors;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        rdy;
        logic        fl;
        logic        wbw;
        logic [4:0]  wbrd;
        logic        e_iss;
        logic        e_stl;
        logic [31:0] e_busy;
        logic [3:0]  e_out;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    id_scoreboard #(.MAX_OUTSTANDING(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_reg_wen_i(id_reg_wen_i),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i), .wb_wen_i(wb_wen_i),
        .wb_rd_addr_i(wb_rd_addr_i), .issue_o(issue_o), .stall_o(stall_o),
        .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //           rst   vld   rs1   rs2   rd    wen   rdy   fl    wbw   wbrd   iss   stl   busy      out   err   cnt
        // RAW on x5
        vecs[0]  = '{1'b1,1'b1,5'd0,5'd0,5'd5,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h0,    4'd0,1'b0,16'd0};
        vecs[1]  = '{1'b1,1'b1,5'd5,5'd1,5'd6,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h20,   4'd1,1'b0,16'd0};
        vecs[2]  = '{1'b1,1'b1,5'd5,5'd1,5'd6,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h20,   4'd1,1'b0,16'd1};
        vecs[3]  = '{1'b1,1'b1,5'd5,5'd1,5'd6,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h20,   4'd1,1'b0,16'd2};
        vecs[4]  = '{1'b1,1'b1,5'd5,5'd1,5'd6,1'b1,1'b1,1'b0,1'b1,5'd5, 1'b0,1'b1,32'h20,   4'd1,1'b0,16'd3};
        vecs[5]  = '{1'b1,1'b1,5'd5,5'd1,5'd6,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h0,    4'd0,1'b0,16'd4};
        vecs[6]  = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b1,5'd6, 1'b0,1'b0,32'h40,   4'd1,1'b0,16'd4};
        // x0 destination and unused sources
        vecs[7]  = '{1'b1,1'b1,5'd0,5'd0,5'd0,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h0,    4'd0,1'b0,16'd4};
        vecs[8]  = '{1'b1,1'b1,5'd0,5'd0,5'd8,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h0,    4'd0,1'b0,16'd4};
        vecs[9]  = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b1,5'd8, 1'b0,1'b0,32'h100,  4'd1,1'b0,16'd4};
        // capacity: fill x1..x4, then x7 waits for a free slot
        vecs[10] = '{1'b1,1'b1,5'd0,5'd0,5'd1,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h0,    4'd0,1'b0,16'd4};
        vecs[11] = '{1'b1,1'b1,5'd0,5'd0,5'd2,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h2,    4'd1,1'b0,16'd4};
        vecs[12] = '{1'b1,1'b1,5'd0,5'd0,5'd3,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h6,    4'd2,1'b0,16'd4};
        vecs[13] = '{1'b1,1'b1,5'd0,5'd0,5'd4,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'hE,    4'd3,1'b0,16'd4};
        vecs[14] = '{1'b1,1'b1,5'd0,5'd0,5'd7,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h1E,   4'd4,1'b0,16'd4};
        vecs[15] = '{1'b1,1'b1,5'd0,5'd0,5'd7,1'b1,1'b1,1'b0,1'b1,5'd1, 1'b0,1'b1,32'h1E,   4'd4,1'b0,16'd5};
        vecs[16] = '{1'b1,1'b1,5'd0,5'd0,5'd7,1'b1,1'b1,1'b0,1'b1,5'd2, 1'b1,1'b0,32'h1C,   4'd3,1'b0,16'd6};
        // writeback to an idle register raises the sticky error
        vecs[17] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b1,5'd9, 1'b0,1'b0,32'h98,   4'd3,1'b0,16'd6};
        vecs[18] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,32'h98,   4'd3,1'b1,16'd6};
        // WAW on x3
        vecs[19] = '{1'b1,1'b1,5'd0,5'd0,5'd3,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h98,   4'd3,1'b1,16'd6};
        vecs[20] = '{1'b1,1'b1,5'd0,5'd0,5'd3,1'b1,1'b1,1'b0,1'b1,5'd3, 1'b0,1'b1,32'h98,   4'd3,1'b1,16'd7};
        vecs[21] = '{1'b1,1'b1,5'd0,5'd0,5'd3,1'b1,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,32'h90,   4'd2,1'b1,16'd8};
        // backpressure then flush
        vecs[22] = '{1'b1,1'b1,5'd0,5'd0,5'd10,1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,1'b1,32'h98,   4'd3,1'b1,16'd8};
        vecs[23] = '{1'b1,1'b1,5'd0,5'd0,5'd10,1'b1,1'b0,1'b1,1'b0,5'd0,1'b0,1'b0,32'h98,   4'd3,1'b1,16'd9};
        vecs[24] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,32'h98,   4'd3,1'b1,16'd9};
        // rs2 RAW
        vecs[25] = '{1'b1,1'b1,5'd0,5'd4,5'd0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,32'h98,   4'd3,1'b1,16'd9};
        vecs[26] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,32'h98,   4'd3,1'b1,16'd10};
        // mid-run reset discards tracking; a late writeback is then an error
        vecs[27] = '{1'b0,1'b1,5'd0,5'd0,5'd11,1'b1,1'b1,1'b0,1'b0,5'd0,1'b0,1'b1,32'h98,   4'd3,1'b1,16'd10};
        vecs[28] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b1,5'd4, 1'b0,1'b0,32'h0,    4'd0,1'b0,16'd0};
        vecs[29] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0,    4'd0,1'b1,16'd0};

        rst_n = 1'b0; id_valid_i = 1'b0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        id_rd_addr_i = 5'd0; id_reg_wen_i = 1'b0; ex_ready_i = 1'b1; flush_i = 1'b0;
        wb_wen_i = 1'b0; wb_rd_addr_i = 5'd0;

        // Two reset cycles with a valid, otherwise issuable instruction in ID.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            rst_n = 1'b0; id_valid_i = 1'b1; id_rd_addr_i = 5'd5; id_reg_wen_i = 1'b1;
            #1;
            chk("rst_issue", r, {31'd0, issue_o}, 32'd0);
            chk("rst_stall", r, {31'd0, stall_o}, 32'd1);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst;
            id_valid_i    = vecs[i].vld;
            id_rs1_addr_i = vecs[i].rs1;
            id_rs2_addr_i = vecs[i].rs2;
            id_rd_addr_i  = vecs[i].rd;
            id_reg_wen_i  = vecs[i].wen;
            ex_ready_i    = vecs[i].rdy;
            flush_i       = vecs[i].fl;
            wb_wen_i      = vecs[i].wbw;
            wb_rd_addr_i  = vecs[i].wbrd;
            #1;
            chk("issue",       i, {31'd0, issue_o},       {31'd0, vecs[i].e_iss});
            chk("stall",       i, {31'd0, stall_o},       {31'd0, vecs[i].e_stl});
            chk("busy",        i, busy_o,                 vecs[i].e_busy);
            chk("outstanding", i, {28'd0, outstanding_o}, {28'd0, vecs[i].e_out});
            chk("err",         i, {31'd0, err_o},         {31'd0, vecs[i].e_err});
            chk("stall_cnt",   i, {16'd0, stall_cnt_o},   {16'd0, vecs[i].e_cnt});
        end

        // Hand sequence: a wb clearing rs1 in cycle N does not bypass into cycle N.
        @(negedge clk);
        rst_n = 1'b1; id_valid_i = 1'b1; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        id_rd_addr_i = 5'd12; id_reg_wen_i = 1'b1; ex_ready_i = 1'b1; flush_i = 1'b0;
        wb_wen_i = 1'b0; wb_rd_addr_i = 5'd0;
        #1;
        chk("seq_issue_x12", 0, {31'd0, issue_o}, 32'd1);
        @(negedge clk);
        id_rs1_addr_i = 5'd12; id_rd_addr_i = 5'd13; wb_wen_i = 1'b1; wb_rd_addr_i = 5'd12;
        #1;
        chk("seq_nobypass_stall", 1, {31'd0, stall_o}, 32'd1);
        chk("seq_nobypass_busy", 1, busy_o, 32'h1000);
        @(negedge clk);
        wb_wen_i = 1'b0; wb_rd_addr_i = 5'd0;
        #1;
        chk("seq_after_wb_issue", 2, {31'd0, issue_o}, 32'd1);
        chk("seq_after_wb_busy", 2, busy_o, 32'h0);
        chk("seq_after_wb_cnt", 2, {16'd0, stall_cnt_o}, 32'd1);
        @(negedge clk);
        id_valid_i = 1'b0;
        #1;
        chk("seq_x13_busy", 3, busy_o, 32'h2000);
        chk("seq_x13_out", 3, {28'd0, outstanding_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Issue scheduler for the decode stage: tracks which architectural registers have a write outstanding in EX/MEM/WB.
- Decides each cycle whether the instruction held in ID may be passed to id_ex (issue) or whether IF/ID must hold (stall).
- Consumes decode's register-address and write-enable outputs plus writeback's commit signals.
- Keeps a per-register busy bitmap, an outstanding-write counter, a sticky protocol-error flag and a saturating stall-cycle counter.

Parameters:
- MAX_OUTSTANDING, 4: maximum register writes in flight. Range 1..15.
- STALL_CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- id_valid_i  input  1  ID holds a valid instruction.
- id_rs1_addr_i  input  5  rs1 read address from decode; 0 means unused.
- id_rs2_addr_i  input  5  rs2 read address from decode; 0 means unused.
- id_rd_addr_i  input  5  destination register from decode.
- id_reg_wen_i  input  1  instruction writes rd.
- ex_ready_i  input  1  id_ex can accept an instruction this cycle.
- flush_i  input  1  kill the instruction in ID this cycle (branch/jump taken).
- wb_wen_i  input  1  writeback commits a register write this cycle.
- wb_rd_addr_i  input  5  writeback destination.
- issue_o  output  1  id_ex captures the ID instruction at the next edge.
- stall_o  output  1  IF and IF/ID hold their contents.
- busy_o  output  32  scoreboard bitmap; bit n = write to xn pending.
- outstanding_o  output  4  number of pending writes.
- err_o  output  1  sticky: writeback to a register that was not busy.
- stall_cnt_o  output  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low at edge): busy_o=0, outstanding_o=0, err_o=0, stall_cnt_o=0.
- While rst_n is low, issue_o=0 and stall_o=1 (combinational gating).
- Register x0 is never busy. Source or destination address 0 never creates a hazard and never sets busy. busy_o[0] is constant 0.
- wr = id_reg_wen_i & (id_rd_addr_i != 0).
- hazard = id_valid_i & ( busy[rs1] | busy[rs2] | (wr & busy[rd]) | (wr & outstanding_o == MAX_OUTSTANDING) ).
  - rs1 check is RAW; rs2 check is RAW; the busy[rd] check is WAW.
  - All checks use the registered busy/outstanding values.
  - There is no same-cycle bypass from writeback. A consumer whose source is cleared by wb in cycle N issues no earlier than cycle N+1.
- issue_o = rst_n & id_valid_i & ~flush_i & ~hazard & ex_ready_i.
- stall_o = ~rst_n | (id_valid_i & ~flush_i & (hazard | ~ex_ready_i)).
- flush_i has priority: issue_o=0 and stall_o=0, so the front end refetches. Scoreboard state is untouched; already-issued writes still retire.
- Set: issue_o & wr sets busy[rd] at the next edge.
- Clear: wb_wen_i & wb_rd_addr_i!=0 & busy[wb_rd_addr_i] clears that bit at the next edge.
  - Same register set and cleared in one cycle is impossible because of the WAW check. If it ever occurs, the set wins.
- outstanding_o: +1 on set, -1 on clear, unchanged when both or neither occur. It never exceeds MAX_OUTSTANDING and never underflows.
- wb_wen_i with a nonzero address whose busy bit is 0: no state change; err_o set to 1 and held until reset.
- stall_cnt_o increments on every cycle with stall_o=1 and rst_n=1. It saturates at all-ones.
- Reset asserted mid-operation discards all pending tracking. Writebacks arriving after reset then raise err_o, which is the intended diagnostic.
- issue_o and stall_o are purely combinational from inputs and registered state: zero-cycle latency. Scoreboard updates are visible one cycle after the edge.

Test Plan:
- Reset: hold rst_n=0 two cycles with id_valid_i=1 -> issue_o=0, stall_o=1; after release busy_o=0, outstanding_o=0, err_o=0, stall_cnt_o=0.
- RAW: issue addi x5 (rd=5, wen) at cycle 0 -> busy_o=0x20 at cycle 1. add x6,x5,x1 in ID stalls: stall_o=1, issue_o=0. Pulse wb x5 at cycle 4 -> busy_o[5]=0 at cycle 5, issue_o=1 at cycle 5, stall_cnt_o=4.
- x0 and unused sources: addi x0,x0,1 followed by add with rs2=0 -> no busy bit set, both issue back-to-back, stall_o never 1.
- Capacity (MAX_OUTSTANDING=4): issue writes to x1..x4, then addi x7 in ID -> stall_o=1, outstanding_o=4. Wb x1 -> outstanding_o=3, and x7 issues next cycle. A simultaneous issue and wb in one cycle leaves the count unchanged.
- Error/WAW: wb_wen_i with rd=9 while busy_o[9]=0 -> err_o=1 and stays 1, busy_o unchanged. With busy_o[3]=1, an instruction writing x3 (no source hazard) stalls until x3 clears.
- Backpressure/flush: ex_ready_i=0 with no hazard -> stall_o=1, busy_o unchanged. Asserting flush_i in the same cycle -> stall_o=0, issue_o=0, busy_o unchanged.
